// File: rtl/audio_sample_fifo_pkg.sv
// Shared audio constants and the stereo sample type for the HDMI audio path.
package audio_pkg;
  localparam int         SAMPLE_W_DEF = 24;
  localparam int         TICK_DIV_48K = 625;
  localparam logic [4:0] GAIN_UNITY   = 5'd8;

  typedef struct packed {
    logic signed [SAMPLE_W_DEF-1:0] l;
    logic signed [SAMPLE_W_DEF-1:0] r;
  } stereo_sample_t;
endpackage

// File: rtl/audio_sample_fifo_if.sv
// Producer handshake plus held stereo output bus of the audio sample FIFO.
interface audio_sample_fifo_if #(parameter int SAMPLE_W = 24);
  logic                       in_valid;
  logic                       in_ready;
  logic signed [SAMPLE_W-1:0] in_left;
  logic signed [SAMPLE_W-1:0] in_right;
  logic signed [SAMPLE_W-1:0] audioL;
  logic signed [SAMPLE_W-1:0] audioR;
  logic                       sample_tick;

  modport master (output in_valid, in_left, in_right,
                  input  in_ready, audioL, audioR, sample_tick);
  modport slave  (input  in_valid, in_left, in_right,
                  output in_ready, audioL, audioR, sample_tick);
endinterface

// File: rtl/audio_sample_fifo_sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers and an explicit occupancy counter.
module sync_fifo #(
  parameter int DATA_W = 48,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    pop,
  output logic [DATA_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;

  // Storage is not reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/audio_sample_fifo.sv
// Audio sample FIFO with 48 kHz tick, underrun hold/count and optional gain stage.
// Build option: define AUDIO_GAIN_EN to scale popped samples by gain/8 with saturation.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = TICK_DIV_48K
) (
  input  logic                    clk,
  input  logic                    rst_n,
  audio_sample_fifo_if.slave      bus,
  input  logic [4:0]              gain,
  output logic [$clog2(DEPTH):0]  level,
  output logic [15:0]             underrun_count
);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]           tick_cnt;
  logic                       tick_q;
  logic                       push, pop;
  logic [1:0][SAMPLE_W-1:0]   head_ch, gained_ch;

  // tick_q is high exactly while the counter sits at TICK_DIV-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
    end else begin
      tick_cnt <= (tick_cnt == CNT_W'(TICK_DIV-1)) ? '0 : tick_cnt + 1'b1;
      tick_q   <= (tick_cnt == CNT_W'(TICK_DIV-2));
    end
  end

  assign bus.sample_tick = tick_q;
  assign bus.in_ready    = (level != LVL_W'(DEPTH));
  assign push            = bus.in_valid && bus.in_ready;
  assign pop             = tick_q && (level != '0);

  sync_fifo #(.DATA_W(2*SAMPLE_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data ({bus.in_left, bus.in_right}),
    .pop     (pop),
    .rd_data (head_ch),
    .level   (level)
  );

  // Channel 1 is left, channel 0 is right.
`ifdef AUDIO_GAIN_EN
  localparam logic signed [SAMPLE_W+5:0] SAT_HI = (SAMPLE_W+6)'((1 << (SAMPLE_W-1)) - 1);
  localparam logic signed [SAMPLE_W+5:0] SAT_LO = ~SAT_HI;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic signed [SAMPLE_W+5:0] prod, shr;
    assign prod = (SAMPLE_W+6)'($signed(head_ch[c])) * (SAMPLE_W+6)'($signed({1'b0, gain}));
    assign shr  = prod >>> 3;
    assign gained_ch[c] = (shr > SAT_HI) ? SAT_HI[SAMPLE_W-1:0] :
                          (shr < SAT_LO) ? SAT_LO[SAMPLE_W-1:0] : shr[SAMPLE_W-1:0];
  end
`else
  logic unused_gain;
  assign unused_gain = ^gain;
  assign gained_ch   = head_ch;
`endif

  // Underrun keeps the last output pair; no zero-fill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.audioL     <= '0;
      bus.audioR     <= '0;
      underrun_count <= '0;
    end else if (tick_q) begin
      if (pop) begin
        bus.audioL <= gained_ch[1];
        bus.audioR <= gained_ch[0];
      end else if (underrun_count != 16'hFFFF) begin
        underrun_count <= underrun_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo; gain expectations follow AUDIO_GAIN_EN.
module tb_audio_sample_fifo;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  gain;
  logic [4:0]  level;
  logic [15:0] underrun_count;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  audio_sample_fifo_if #(.SAMPLE_W(24)) bus ();

  audio_sample_fifo #(.SAMPLE_W(24), .DEPTH(16), .TICK_DIV(625)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .gain           (gain),
    .level          (level),
    .underrun_count (underrun_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] s24(input int v);
    return {8'h0, v[23:0]};
  endfunction

  function automatic logic [31:0] outl();
    return {8'h0, bus.audioL};
  endfunction

  function automatic logic [31:0] outr();
    return {8'h0, bus.audioR};
  endfunction

  // Returns just after the edge that raised sample_tick.
  task automatic wait_tick();
    for (int i = 0; i < 700; i++) begin
      step();
      if (bus.sample_tick) return;
    end
    chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_pair(input int l, input int r);
    bus.in_valid = 1'b1;
    bus.in_left  = l[23:0];
    bus.in_right = r[23:0];
    step();
    bus.in_valid = 1'b0;
  endtask

  int r0, t1, t2, acc;
  int gl [4];
  int el [4];
  int er [4];

  initial begin
    rst_n        = 1'b0;
    gain         = GAIN_UNITY;
    bus.in_valid = 1'b0;
    bus.in_left  = '0;
    bus.in_right = '0;

    // 1: reset state, idle tick period, underrun counting
    step(); step();
    r0 = cyc;
    chk("rst_audioL", outl(), 32'd0);
    chk("rst_audioR", outr(), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_underrun", 32'(underrun_count), 32'd0);
    chk("rst_tick", 32'(bus.sample_tick), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    wait_tick();
    t1 = cyc;
    chk("tick_first", 32'(t1 - r0), 32'd624);
    step();
    chk("tick_one_cycle", 32'(bus.sample_tick), 32'd0);
    wait_tick();
    t2 = cyc;
    chk("tick_period", 32'(t2 - t1), 32'd625);
    step();
    chk("idle_underrun", 32'(underrun_count), 32'd2);
    chk("idle_audioL", outl(), 32'd0);
    chk("idle_level", 32'(level), 32'd0);

    // 2: three pairs, ordered release, hold on the 4th tick
    for (int n = 1; n <= 3; n++) push_pair(n, -n);
    chk("burst_level", 32'(level), 32'd3);
    for (int n = 1; n <= 3; n++) begin
      wait_tick();
      chk("pre_tick_hold", outl(), s24(n - 1));
      step();
      chk("pop_L", outl(), s24(n));
      chk("pop_R", outr(), s24(-n));
    end
    wait_tick();
    step();
    chk("under_hold_L", outl(), s24(3));
    chk("under_hold_R", outr(), s24(-3));
    chk("under_count", 32'(underrun_count), 32'd3);

    // 3: saturate to full with a 20-cycle valid burst
    acc = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_left  = 24'(100 + acc);
      bus.in_right = 24'(200 + acc);
      if (bus.in_ready) acc++;
      step();
    end
    bus.in_valid = 1'b0;
    chk("full_accepts", 32'(acc), 32'd16);
    chk("full_level", 32'(level), 32'd16);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    wait_tick();
    step();
    chk("full_pop_L", outl(), s24(100));
    chk("full_pop_level", 32'(level), 32'd15);
    chk("full_pop_ready", 32'(bus.in_ready), 32'd1);

    // 4a: full FIFO, push on the tick cycle is refused, pop still happens
    push_pair(116, 216);
    chk("refill_level", 32'(level), 32'd16);
    wait_tick();
    bus.in_valid = 1'b1;
    bus.in_left  = 24'd999;
    bus.in_right = 24'd999;
    chk("tick_full_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.in_valid = 1'b0;
    chk("tick_full_level", 32'(level), 32'd15);
    chk("tick_full_pop", outl(), s24(101));
    for (int i = 0; i < 15; i++) begin
      wait_tick();
      step();
      chk("drain_L", outl(), s24(102 + i));
      chk("drain_R", outr(), s24(202 + i));
    end
    chk("drain_level", 32'(level), 32'd0);

    // 4b: empty FIFO, push on the tick cycle lands while the tick underruns
    wait_tick();
    bus.in_valid = 1'b1;
    bus.in_left  = 24'd500;
    bus.in_right = 24'd600;
    step();
    bus.in_valid = 1'b0;
    chk("tick_empty_level", 32'(level), 32'd1);
    chk("tick_empty_under", 32'(underrun_count), 32'd4);
    chk("tick_empty_hold", outl(), s24(116));
    wait_tick();
    step();
    chk("late_pop_L", outl(), s24(500));
    chk("late_pop_R", outr(), s24(600));
    chk("late_pop_level", 32'(level), 32'd0);

    // 5: gain stage
    gl = '{16, 16, 8, 4};
`ifdef AUDIO_GAIN_EN
    el = '{32'h7FFFFF, 32'h800000, 32'h123456, 32'h000080};
    er = '{32'h000200, 32'hFFFE00, 32'hEDCBAA, 32'h000080};
`else
    el = '{32'h600000, 32'hA00000, 32'h123456, 32'h000100};
    er = '{32'h000100, 32'hFFFF00, 32'hEDCBAA, 32'h000100};
`endif
    push_pair(32'h600000, 32'h000100);
    push_pair(32'hA00000, 32'hFFFF00);
    push_pair(32'h123456, 32'hEDCBAA);
    push_pair(32'h000100, 32'h000100);
    for (int i = 0; i < 4; i++) begin
      gain = gl[i][4:0];
      wait_tick();
      step();
      chk("gain_L", outl(), s24(el[i]));
      chk("gain_R", outr(), s24(er[i]));
    end
    gain = GAIN_UNITY;

    // 6: reset mid-stream discards everything
    for (int n = 0; n < 7; n++) push_pair(300 + n, 400 + n);
    chk("pre_rst_level", 32'(level), 32'd7);
    rst_n = 1'b0;
    step();
    r0 = cyc;
    rst_n = 1'b1;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_audioL", outl(), 32'd0);
    chk("mid_rst_audioR", outr(), 32'd0);
    chk("mid_rst_under", 32'(underrun_count), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    wait_tick();
    chk("post_rst_tick", 32'(cyc - r0), 32'd624);
    step();
    chk("post_rst_under", 32'(underrun_count), 32'd1);
    chk("post_rst_audioL", outl(), 32'd0);
    chk("post_rst_level", 32'(level), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
